linkspeed_sb_arbiter: RTL

//  Shares the single sideband transmit port between the TX-side and RX-side request FSMs of the LINKSPEED

---
 rtl/linkspeed_sb_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/linkspeed_sb_arbiter.sv
// linkspeed_sb_arbiter
// Shares the single sideband transmit port between the LINKSPEED TX-side and
// RX-side request FSMs. Each requester owns a one-deep holding buffer; pending
// buffers are granted round-robin, each grant produces a single o_valid pulse,
// and the grant is retired on the sideband busy falling edge or by a timeout.

module linkspeed_sb_arbiter #(
  parameter int unsigned            MSG_W     = 4,
  parameter int unsigned            TIMEOUT_W = 16,
  parameter logic [TIMEOUT_W-1:0]   TIMEOUT   = 16'd4000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_tx_valid,
  input  logic [MSG_W-1:0] i_tx_msg,
  input  logic             i_rx_valid,
  input  logic [MSG_W-1:0] i_rx_msg,
  input  logic             i_busy,
  input  logic             i_falling_edge_busy,
  output logic             o_valid,
  output logic [MSG_W-1:0] o_sideband_message,
  output logic             o_tx_done,
  output logic             o_rx_done,
  output logic             o_tx_pending,
  output logic             o_rx_pending,
  output logic             o_drop_err,
  output logic             o_timeout_err
);

  // Requester identifiers used by the select and round-robin registers.
  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;

  // Counter constants kept at the counter width so comparisons stay exact.
  localparam logic [TIMEOUT_W-1:0] CNT_ONE  = {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_W-1:0] CNT_MAX  = {TIMEOUT_W{1'b1}};
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT - CNT_ONE;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 sel_q, sel_d;
  logic                 rr_q, rr_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic [MSG_W-1:0]     msg_q, msg_d;

  logic [MSG_W-1:0]     tx_buf_q, tx_buf_d;
  logic [MSG_W-1:0]     rx_buf_q, rx_buf_d;
  logic                 tx_pend_q, tx_pend_d;
  logic                 rx_pend_q, rx_pend_d;

  logic                 tx_done_q, tx_done_d;
  logic                 rx_done_q, rx_done_d;
  logic                 drop_q, drop_d;
  logic                 terr_q, terr_d;

  // Buffer release requests from the FSM; they let a same-cycle strobe refill.
  logic                 tx_free;
  logic                 rx_free;

  // Grant selection, counter and completion tracking for the current grant.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    rr_d      = rr_q;
    cnt_d     = cnt_q;
    msg_d     = msg_q;
    tx_done_d = 1'b0;
    rx_done_d = 1'b0;
    terr_d    = terr_q;
    tx_free   = 1'b0;
    rx_free   = 1'b0;

    if (!i_en) begin
      state_d = IDLE;
      rr_d    = REQ_TX;
      cnt_d   = '0;
      msg_d   = '0;
      terr_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if ((tx_pend_q || rx_pend_q) && !i_busy) begin
            if (tx_pend_q && !rx_pend_q) begin
              sel_d = REQ_TX;
            end else if (rx_pend_q && !tx_pend_q) begin
              sel_d = REQ_RX;
            end else begin
              sel_d = rr_q;
            end
            msg_d   = (sel_d == REQ_TX) ? tx_buf_q : rx_buf_q;
            state_d = ISSUE;
          end
        end

        ISSUE: begin
          cnt_d   = '0;
          state_d = WAIT_BUSY;
        end

        WAIT_BUSY: begin
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_ONE;
          end
          if (i_falling_edge_busy) begin
            tx_free   = (sel_q == REQ_TX);
            rx_free   = (sel_q == REQ_RX);
            tx_done_d = (sel_q == REQ_TX);
            rx_done_d = (sel_q == REQ_RX);
            rr_d      = ~sel_q;
            state_d   = IDLE;
          end else if (cnt_q == CNT_LAST) begin
            tx_free = (sel_q == REQ_TX);
            rx_free = (sel_q == REQ_RX);
            terr_d  = 1'b1;
            rr_d    = ~rr_q;
            state_d = IDLE;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Holding buffers: capture strobes, refill on same-cycle release, flag drops.
  always_comb begin
    tx_buf_d  = tx_buf_q;
    rx_buf_d  = rx_buf_q;
    tx_pend_d = tx_pend_q;
    rx_pend_d = rx_pend_q;
    drop_d    = drop_q;

    if (!i_en) begin
      tx_buf_d  = '0;
      rx_buf_d  = '0;
      tx_pend_d = 1'b0;
      rx_pend_d = 1'b0;
      drop_d    = 1'b0;
    end else begin
      if (i_tx_valid) begin
        if (!tx_pend_q || tx_free) begin
          tx_buf_d  = i_tx_msg;
          tx_pend_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if (tx_free) begin
        tx_pend_d = 1'b0;
      end

      if (i_rx_valid) begin
        if (!rx_pend_q || rx_free) begin
          rx_buf_d  = i_rx_msg;
          rx_pend_d = 1'b1;
        end else begin
          drop_d = 1'b1;
        end
      end else if (rx_free) begin
        rx_pend_d = 1'b0;
      end
    end
  end

  // State and datapath registers with asynchronous reset to the idle, empty state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      sel_q     <= REQ_TX;
      rr_q      <= REQ_TX;
      cnt_q     <= '0;
      msg_q     <= '0;
      tx_buf_q  <= '0;
      rx_buf_q  <= '0;
      tx_pend_q <= 1'b0;
      rx_pend_q <= 1'b0;
      tx_done_q <= 1'b0;
      rx_done_q <= 1'b0;
      drop_q    <= 1'b0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      rr_q      <= rr_d;
      cnt_q     <= cnt_d;
      msg_q     <= msg_d;
      tx_buf_q  <= tx_buf_d;
      rx_buf_q  <= rx_buf_d;
      tx_pend_q <= tx_pend_d;
      rx_pend_q <= rx_pend_d;
      tx_done_q <= tx_done_d;
      rx_done_q <= rx_done_d;
      drop_q    <= drop_d;
      terr_q    <= terr_d;
    end
  end

  assign o_valid            = (state_q == ISSUE);
  assign o_sideband_message = msg_q;
  assign o_tx_done          = tx_done_q;
  assign o_rx_done          = rx_done_q;
  assign o_tx_pending       = tx_pend_q;
  assign o_rx_pending       = rx_pend_q;
  assign o_drop_err         = drop_q;
  assign o_timeout_err      = terr_q;

endmodule
